// File: rtl/ctrl_frame_capturer_if.sv
// Bus bundle for ctrl_frame_capturer: RX FIFO read side plus the picosoc iomem port.
// master = SoC/FIFO side driving requests, slave = the capturer.
interface ctrl_frame_capturer_if;
    logic [7:0]  i_fifo_dout;
    logic        i_fifo_del;
    logic        i_fifo_empty;
    logic        o_fifo_rden;
    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;

    modport master (
        output i_fifo_dout, i_fifo_del, i_fifo_empty,
        output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
        input  o_fifo_rden, iomem_ready, iomem_rdata
    );

    modport slave (
        input  i_fifo_dout, i_fifo_del, i_fifo_empty,
        input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
        output o_fifo_rden, iomem_ready, iomem_rdata
    );
endinterface

// File: rtl/ctrl_frame_capturer.sv
// Drains one frame at a time from the CPU-bound RX FIFO into a word RAM read over iomem.
// Optional macro CTRL_RX_IRQ_EN adds the irq output and the irq_en status bit [27].
module ctrl_frame_capturer #(
    parameter int unsigned MAX_WORDS    = 16,
    parameter logic [7:0]  CFG_ADDR_TAG = 8'h16,
    parameter logic [7:0]  RAM_ADDR_TAG = 8'h06
) (
    input  logic                  clk,
    input  logic                  arst,
    ctrl_frame_capturer_if.slave  bus
`ifdef CTRL_RX_IRQ_EN
    ,
    output logic                  irq
`endif
);
    localparam int unsigned AW        = $clog2(MAX_WORDS);
    localparam int unsigned CAP_BYTES = 4 * MAX_WORDS;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RX   = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t        r_state;
    logic [31:0]   r_ram [MAX_WORDS];
    logic [15:0]   r_count;
    logic [15:0]   r_length;
    logic          r_frame_valid;
    logic          r_rx_enable;
    logic          r_truncated;
    logic          r_ready;
    logic [31:0]   r_rdata;

    logic          w_pop;
    logic          w_cfg_sel;
    logic          w_ram_sel;
    logic          w_accept;
    logic          w_hi_wr;
    logic          w_release;
    logic          w_store;
    logic          w_irq_en;
    logic [15:0]   w_count_inc;
    logic [31:0]   w_status;
    logic [AW-1:0] w_ram_idx;
    logic [AW-1:0] w_wr_idx;
    logic [1:0]    w_lane;
    logic          w_unused;

`ifdef CTRL_RX_IRQ_EN
    logic          r_irq_en;
    logic          r_irq;
    assign w_irq_en = r_irq_en;
    assign irq      = r_irq;
`else
    assign w_irq_en = 1'b0;
`endif

    // FIFO is popped combinationally only while receiving; S_HOLD backpressures it
    assign w_pop           = (r_state == S_RX) && !bus.i_fifo_empty;
    assign bus.o_fifo_rden = w_pop;

    assign w_cfg_sel   = (bus.iomem_addr[31:24] == CFG_ADDR_TAG);
    assign w_ram_sel   = (bus.iomem_addr[31:24] == RAM_ADDR_TAG);
    assign w_accept    = bus.iomem_valid && !r_ready && (w_cfg_sel || w_ram_sel);
    assign w_hi_wr     = w_accept && w_cfg_sel && bus.iomem_wstrb[3];
    assign w_release   = w_hi_wr && bus.iomem_wdata[28] && (r_state == S_HOLD);
    assign w_ram_idx   = bus.iomem_addr[AW+1:2];

    assign w_count_inc = (r_count == 16'hFFFF) ? r_count : r_count + 16'd1;
    assign w_store     = (32'(r_count) < CAP_BYTES);
    assign w_wr_idx    = r_count[AW+1:2];
    assign w_lane      = r_count[1:0];

    assign w_status = {r_frame_valid, r_rx_enable, r_truncated, 1'b0, w_irq_en,
                       11'd0, r_length};

    assign bus.iomem_ready = r_ready;
    assign bus.iomem_rdata = r_rdata;

    // Address/data bits outside the decoded fields are intentionally ignored
    assign w_unused = ^{bus.iomem_addr, bus.iomem_wdata, bus.iomem_wstrb};

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state       <= S_IDLE;
            r_count       <= '0;
            r_length      <= '0;
            r_frame_valid <= 1'b0;
            r_rx_enable   <= 1'b0;
            r_truncated   <= 1'b0;
            r_ready       <= 1'b0;
            r_rdata       <= '0;
`ifdef CTRL_RX_IRQ_EN
            r_irq_en      <= 1'b0;
            r_irq         <= 1'b0;
`endif
            for (int unsigned i = 0; i < MAX_WORDS; i++) begin
                r_ram[i] <= '0;
            end
        end else begin
            r_ready <= w_accept;
            // Read data reflects state before any write in the same access
            if (w_accept) begin
                r_rdata <= w_cfg_sel ? w_status : r_ram[w_ram_idx];
            end
            if (w_hi_wr) begin
                r_rx_enable <= bus.iomem_wdata[30];
`ifdef CTRL_RX_IRQ_EN
                r_irq_en    <= bus.iomem_wdata[27];
`endif
            end
`ifdef CTRL_RX_IRQ_EN
            r_irq <= r_frame_valid && r_irq_en;
`endif
            case (r_state)
                S_IDLE: begin
                    if (r_rx_enable && !bus.i_fifo_empty) begin
                        r_state     <= S_RX;
                        r_count     <= '0;
                        r_truncated <= 1'b0;
                    end
                end
                S_RX: begin
                    if (w_pop) begin
                        if (w_store) begin
                            r_ram[w_wr_idx][{w_lane, 3'b000} +: 8] <= bus.i_fifo_dout;
                        end else begin
                            r_truncated <= 1'b1;
                        end
                        r_count <= w_count_inc;
                        if (bus.i_fifo_del) begin
                            r_length      <= w_count_inc;
                            r_frame_valid <= 1'b1;
                            r_state       <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (w_release) begin
                        r_frame_valid <= 1'b0;
                        r_state       <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ctrl_frame_capturer.sv
// Directed/randomized bench for ctrl_frame_capturer against a byte-queue reference model.
// Build with +define+CTRL_RX_IRQ_EN to also exercise the irq output.
module tb_ctrl_frame_capturer;
    localparam int unsigned MAX_WORDS = 16;
    localparam int unsigned CAP       = 4 * MAX_WORDS;
    localparam logic [31:0] CFG       = 32'h1600_0000;
    localparam logic [31:0] RAMB      = 32'h0600_0000;

    logic clk = 1'b0;
    logic arst;
    always #5 clk = ~clk;

    ctrl_frame_capturer_if bus();
`ifdef CTRL_RX_IRQ_EN
    logic irq;
`endif

    ctrl_frame_capturer #(
        .MAX_WORDS   (MAX_WORDS),
        .CFG_ADDR_TAG(8'h16),
        .RAM_ADDR_TAG(8'h06)
    ) dut (
        .clk (clk),
        .arst(arst),
        .bus (bus)
`ifdef CTRL_RX_IRQ_EN
        ,
        .irq (irq)
`endif
    );

    // FIFO model: {del, data} entries, head presented first-word-fall-through
    logic [8:0]  fq[$];
    // Reference model: expected bytes, frame lengths, RAM image, register state
    logic [7:0]  mq[$];
    int          mlen[$];
    logic [31:0] mram[MAX_WORDS];
    bit          m_en, m_irq_en, m_trunc;
    logic [15:0] m_len;

    int n_chk = 0, n_pass = 0, n_fail = 0;

    always begin : fifo_drv
        bit p;
        @(posedge clk);
        p = bus.o_fifo_rden && !bus.i_fifo_empty;
        #1;
        if (p && fq.size() > 0) void'(fq.pop_front());
        bus.i_fifo_empty = (fq.size() == 0);
        bus.i_fifo_dout  = (fq.size() == 0) ? 8'h00 : fq[0][7:0];
        bus.i_fifo_del   = (fq.size() == 0) ? 1'b0  : fq[0][8];
        @(negedge clk);
        bus.i_fifo_empty = (fq.size() == 0);
        bus.i_fifo_dout  = (fq.size() == 0) ? 8'h00 : fq[0][7:0];
        bus.i_fifo_del   = (fq.size() == 0) ? 1'b0  : fq[0][8];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] stat(input bit fv);
        logic ib;
`ifdef CTRL_RX_IRQ_EN
        ib = m_irq_en;
`else
        ib = 1'b0;
`endif
        return {fv, m_en, m_trunc, 1'b0, ib, 11'd0, m_len};
    endfunction

    task automatic bus_acc(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [31:0] r, output bit acked);
        @(negedge clk);
        bus.iomem_valid = 1'b1;
        bus.iomem_addr  = a;
        bus.iomem_wdata = d;
        bus.iomem_wstrb = s;
        acked = 1'b0;
        r     = '0;
        for (int i = 0; i < 8 && !acked; i++) begin
            @(negedge clk);
            if (bus.iomem_ready) begin
                acked = 1'b1;
                r     = bus.iomem_rdata;
            end
        end
        bus.iomem_valid = 1'b0;
        bus.iomem_wstrb = 4'h0;
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] r; bit ak;
        bus_acc(a, 32'h0, 4'h0, r, ak);
        chk({tag, "_ack"}, 32'(ak), 32'd1);
        chk(tag, r, exp);
    endtask

    task automatic set_cfg(input bit en, input bit ie);
        logic [31:0] r; bit ak;
        bus_acc(CFG, {1'b0, en, 2'b00, ie, 27'd0}, 4'hF, r, ak);
        chk("cfg_ack", 32'(ak), 32'd1);
        m_en = en;
        m_irq_en = ie;
    endtask

    task automatic push_bytes(input int n, input bit incr, input int base, input bit del_last);
        logic [7:0] b;
        @(negedge clk);
        for (int k = 0; k < n; k++) begin
            b = incr ? 8'(base + k) : 8'($urandom);
            fq.push_back({(del_last && k == n - 1), b});
            mq.push_back(b);
        end
    endtask

    task automatic push_frame(input int n, input bit incr);
        push_bytes(n, incr, 0, 1'b1);
        mlen.push_back(n);
    endtask

    task automatic wait_fifo_empty();
        int i;
        for (i = 0; i < 200 && fq.size() != 0; i++) @(negedge clk);
        chk("fifo_drain", 32'(fq.size()), 32'd0);
    endtask

    // Wait for frame_valid, then compare status, every RAM word and irq with the model
    task automatic capture_check(input string tag);
        int n, w;
        logic [7:0] b;
        logic [31:0] r; bit ak;
        n = mlen.pop_front();
        for (int k = 0; k < n; k++) begin
            b = mq.pop_front();
            if (k < CAP) begin
                w = k / 4;
                mram[w] = (mram[w] & ~(32'hFF << (8 * (k % 4)))) | (32'(b) << (8 * (k % 4)));
            end
        end
        m_trunc = (n > CAP);
        m_len   = (n > 65535) ? 16'hFFFF : 16'(n);
        r = '0;
        for (int i = 0; i < 300 && !r[31]; i++) bus_acc(CFG, 32'h0, 4'h0, r, ak);
        chk({tag, "_status"}, r, stat(1'b1));
`ifdef CTRL_RX_IRQ_EN
        chk({tag, "_irq"}, 32'(irq), 32'(m_irq_en));
`endif
        for (int i = 0; i < int'(MAX_WORDS); i++) begin
            rd($sformatf("%s_w%0d", tag, i), RAMB | 32'(i << 2), mram[i]);
        end
    endtask

    task automatic release_frame(input bit new_en);
        logic [31:0] r; bit ak;
        bus_acc(CFG, {1'b0, new_en, 1'b0, 1'b1, m_irq_en, 27'd0}, 4'hF, r, ak);
        chk("rel_ack", 32'(ak), 32'd1);
        chk("rel_rdata_pre", r, stat(1'b1));
`ifdef CTRL_RX_IRQ_EN
        chk("irq_at_rel", 32'(irq), 32'(m_irq_en));
        @(negedge clk);
        chk("irq_after_rel", 32'(irq), 32'd0);
`endif
        m_en = new_en;
    endtask

    task automatic count_rden(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.o_fifo_rden) cnt++;
        end
    endtask

    initial begin
        logic [31:0] r; bit ak; int cnt, sz;
        arst = 1'b1;
        bus.iomem_valid = 1'b0; bus.iomem_wstrb = 4'h0;
        bus.iomem_addr = '0; bus.iomem_wdata = '0;
        m_en = 0; m_irq_en = 0; m_trunc = 0; m_len = '0;
        foreach (mram[i]) mram[i] = '0;
        #23;
        chk("rst_ready", 32'(bus.iomem_ready), 32'd0);
        chk("rst_rdata", bus.iomem_rdata, 32'd0);
        chk("rst_rden", 32'(bus.o_fifo_rden), 32'd0);
        arst = 1'b0;

        // Frame waiting in the FIFO while disabled: nothing popped, status zero
        push_frame(8, 1'b0);
        count_rden(12, cnt);
        chk("idle_no_pop", 32'(cnt), 32'd0);
        chk("idle_fifo_level", 32'(fq.size()), 32'd8);
        rd("rst_status", CFG, 32'h0);

        bus_acc(32'h2000_0000, 32'h0, 4'h0, r, ak);
        chk("unmatched_no_ack", 32'(ak), 32'd0);
        bus_acc(CFG, 32'h4000_0000, 4'h7, r, ak);
        rd("no_wstrb3_status", CFG, 32'h0);

        set_cfg(1'b1, 1'b1);
        capture_check("f8");
        release_frame(1'b1);
        set_cfg(1'b1, 1'b0);

        push_frame(64, 1'b1);
        capture_check("f64");
        rd("f64_word0", RAMB, 32'h0302_0100);
        rd("f64_word15", RAMB | 32'h3C, 32'h3F3E_3D3C);
        release_frame(1'b1);

        push_frame(70, 1'b0);
        capture_check("f70");
        rd("f70_len", CFG, 32'hE000_0046);
        release_frame(1'b1);

        bus_acc(RAMB, 32'hFFFF_FFFF, 4'hF, r, ak);
        chk("ramwr_ack", 32'(ak), 32'd1);
        rd("ramwr_ignored", RAMB, mram[0]);

        // Back-to-back frames: second waits while the first is held
        push_frame(5, 1'b0);
        push_frame(9, 1'b0);
        capture_check("bb1");
        sz = fq.size();
        count_rden(10, cnt);
        chk("hold_no_pop", 32'(cnt), 32'd0);
        chk("hold_fifo_level", 32'(fq.size()), 32'(sz));
        release_frame(1'b1);
        capture_check("bb2");
        release_frame(1'b1);

        push_frame(1, 1'b0);
        capture_check("f1");
        release_frame(1'b1);

        // rx_enable dropped mid-frame: frame still completes
        push_bytes(10, 1'b1, 8'h80, 1'b0);
        wait_fifo_empty();
        set_cfg(1'b0, 1'b0);
        push_bytes(10, 1'b1, 8'h8A, 1'b1);
        mlen.push_back(20);
        capture_check("f20");
        release_frame(1'b0);
        push_frame(6, 1'b0);
        count_rden(15, cnt);
        chk("disabled_no_pop", 32'(cnt), 32'd0);
        rd("disabled_status", CFG, stat(1'b0));
        bus_acc(CFG, 32'h1000_0000, 4'hF, r, ak);
        rd("rel_idle_ignored", CFG, stat(1'b0));
        set_cfg(1'b1, 1'b1);
        capture_check("f6");
        release_frame(1'b1);

        // Asynchronous reset in the middle of a frame
        push_frame(30, 1'b0);
        repeat (5) @(negedge clk);
        #2 arst = 1'b1;
        #1;
        chk("amid_rden", 32'(bus.o_fifo_rden), 32'd0);
        chk("amid_ready", 32'(bus.iomem_ready), 32'd0);
        chk("amid_rdata", bus.iomem_rdata, 32'd0);
`ifdef CTRL_RX_IRQ_EN
        chk("amid_irq", 32'(irq), 32'd0);
`endif
        fq.delete(); mq.delete(); mlen.delete();
        m_en = 0; m_irq_en = 0; m_trunc = 0; m_len = '0;
        foreach (mram[i]) mram[i] = '0;
        @(negedge clk);
        arst = 1'b0;
        rd("post_rst_status", CFG, 32'h0);
        rd("post_rst_word0", RAMB, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/ctrl_frame_capturer.md
Name: ctrl_frame_capturer

Overview:
- Receive-side counterpart of the control-frame issuer. Drains one frame per transaction from the CPU-bound switch RX FIFO into a 32-bit-wide frame RAM. The picosoc CPU then reads the frame over the iomem bus.
- Holds the captured frame with backpressure until the CPU releases it. Records byte length and a truncation flag.

Parameters:
- MAX_WORDS, 16, frame RAM depth in 32-bit words; capture limit = 4*MAX_WORDS bytes (power of two, 2..256).
- CFG_ADDR_TAG, 8'h16, iomem_addr[31:24] value selecting the config/status register.
- RAM_ADDR_TAG, 8'h06, iomem_addr[31:24] value selecting the frame RAM window.

Ports:
- clk  in  1  system clock.
- arst  in  1  asynchronous reset, active-high.
- i_fifo_dout  in  8  RX FIFO head byte (first-word-fall-through, valid while !i_fifo_empty).
- i_fifo_del  in  1  head byte is last byte of frame.
- i_fifo_empty  in  1  RX FIFO empty.
- o_fifo_rden  out  1  pop head byte.
- iomem_valid  in  1  picosoc bus request.
- iomem_ready  out  1  one-cycle acknowledge.
- iomem_wstrb  in  4  byte write strobes.
- iomem_addr  in  32  bus address.
- iomem_wdata  in  32  write data.
- iomem_rdata  out  32  read data.
- irq  out  1  frame-available interrupt (only with CTRL_RX_IRQ_EN).

Behaviour:
- Reset (arst high, async): all outputs 0, state S_IDLE, rx_enable=0, frame_valid=0, truncated=0, length=0, RAM cleared. The RX FIFO is reset by the same reset at system level.
- Config/status register (iomem_addr[31:24]==CFG_ADDR_TAG):
  - [31] frame_valid, R.
  - [30] rx_enable, RW.
  - [29] truncated, R.
  - [28] release, W, self-clearing, reads 0.
  - [27] irq_en, RW.
  - [15:0] length, R.
  - All other bits read 0.
  - rx_enable and irq_en are written only when wstrb[3]=1.
  - release is accepted only when wstrb[3]=1 and wdata[28]=1.
- RAM window (tag RAM_ADDR_TAG): word index iomem_addr[log2(MAX_WORDS)+1:2]. Read-only from the bus; writes are acknowledged and ignored.
- Bus timing:
  - iomem_ready pulses 1 cycle, on the cycle after valid && !ready && tag match. rdata is registered with it.
  - No ack for an unmatched tag.
- FSM:
  - S_IDLE: when rx_enable && !i_fifo_empty, go to S_RX; byte count=0, truncated=0.
  - S_RX:
    - o_fifo_rden = !i_fifo_empty (combinational).
    - Each popped byte k is written to ram[k>>2] bits [8*(k&3)+7 : 8*(k&3)], little-endian: byte 0 in [7:0], matching the issuer's byte order.
    - The count increments per pop, saturating at 16'hFFFF.
    - Byte k >= 4*MAX_WORDS is not stored and sets truncated=1.
    - On popping a byte with i_fifo_del=1: length <= count+1 (saturating), then go to S_HOLD.
  - S_HOLD:
    - frame_valid=1; o_fifo_rden=0, so the FIFO is backpressured.
    - A release write clears frame_valid and returns to S_IDLE the next cycle.
- Clearing rx_enable mid-frame does not abort: the frame completes to S_HOLD. rx_enable only gates S_IDLE exit.
- Release written outside S_HOLD is ignored.
- Release and a register read in the same access: rdata returns the pre-release status (frame_valid=1).
- Earliest new-frame start after release: 2 cycles after iomem_ready.
- Words of the RAM not overwritten by a shorter frame keep stale data. Software uses length.
- Single-byte frame (del on first byte): length=1, ram[0][7:0] written.

Optional Feature:
- Macro CTRL_RX_IRQ_EN.
- Defined: irq port exists; irq = frame_valid && irq_en, registered (asserts 1 cycle after entering S_HOLD, deasserts 1 cycle after release).
- Undefined: no irq port; bit [27] reads 0 and writes are ignored.

Test Plan:
- Reset with rx_enable=0 and FIFO holding a frame: o_fifo_rden stays 0; status reads 32'h0.
- Write status 32'h4000_0000, push 64-byte frame 0x00..0x3F: status = 32'h C000_0040 (valid, enabled, len 64); RAM word 0 = 32'h03020100; word 15 = 32'h3F3E3D3C; truncated=0.
- 70-byte frame: all 70 bytes popped, truncated=1, length=70, word 15 = bytes 60..63, status[15:0]=16'd70.
- Two back-to-back frames in the FIFO: second is not popped while S_HOLD. Write 32'h5000_0000 (release+enable) → second frame captured; its length is reported.
- Clear rx_enable after byte 10 of a 20-byte frame: capture completes with length=20; no further frame starts until rx_enable=1.
- CTRL_RX_IRQ_EN with irq_en=1: irq rises 1 cycle after frame_valid, falls 1 cycle after release. With irq_en=0, irq stays 0. Assert arst mid-frame: all state and irq are 0 immediately.
